instr_fetch_sequencer: RTL and testbench
========================================

// Module: instr_fetch_sequencer
// PURPOSE
//   Fetches variable-length instructions one byte at a time from program memory, assembles
//   them into opcode/operand/extension bytes and presents them to the decoder with a
//   valid/ready handshake. Owns the program counter; accepts branch redirects from execute.
//   Sits between the program-memory port and the decoder.
// PARAMETERS
//   ADDR_W    16      program-memory address / PC width
//   RESET_PC  0       PC value loaded at reset (ADDR_W bits)
// PORTS
//   clk             in   1       system clock, all state on rising edge
//   rst_n           in   1       asynchronous active-low reset
//   en              in   1       fetch enable; gates only the start of a new instruction
//   mem_req         out  1       byte read request
//   mem_addr        out  ADDR_W  byte address, stable while mem_req=1
//   mem_ack         in   1       read complete this cycle (valid only when mem_req=1)
//   mem_rdata       in   8       read data, valid when mem_req&mem_ack
//   instr_valid     out  1       assembled instruction available
//   instr_ready     in   1       decoder accepts instruction
//   instr_byte0     out  8       opcode byte
//   instr_byte1     out  8       operand byte 1 (0 if unused)
//   instr_byte2     out  8       operand byte 2 (0 if unused)
//   ext_instr_byte  out  8       extension byte (0 unless byte0[7]=1)
//   instr_len       out  3       instruction length in bytes: 1, 3 or 4
//   instr_pc        out  ADDR_W  address of byte0 of the presented instruction
//   redirect_valid  in   1       load new PC, discard in-flight instruction
//   redirect_pc     in   ADDR_W  redirect target
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC,
//     instr_valid=0, all instr_* bytes=0, instr_len=0, instr_pc=RESET_PC.
//   Length from byte0: byte0[7]=1 -> 4; else byte0[1:0]==00 -> 1; else -> 3.
//   States: IDLE, F0, F1, F2, F3, ISSUE.
//     IDLE: en=1 -> F0 next cycle; else stay.
//     F0..F3: mem_req=1, mem_addr=pc. On mem_ack: latch mem_rdata into byte slot
//       (F0->byte0, F1->byte1, F2->byte2, F3->ext), pc<=pc+1 (wraps 2^ADDR_W-1 -> 0).
//       F0 ack also latches instr_pc<=pc and clears slots 1..3. Next state: F1 if len>1
//       else ISSUE; F1->F2; F2->F3 if len=4 else ISSUE; F3->ISSUE. No ack -> hold state.
//     ISSUE: mem_req=0, instr_valid=1, outputs stable. instr_ready=1 -> valid drops next
//       cycle, go F0 if en=1 else IDLE.
//   Latency (mem_ack same cycle as req): instr_valid rises 1 cycle after the last byte ack;
//     with ready=1 a 1-byte instruction issues every 2 cycles, a 3-byte every 4.
//   en=0 never aborts an instruction in progress; only checked on leaving IDLE/ISSUE.
//   redirect_valid (highest priority, any state): pc<=redirect_pc, instr_valid<=0,
//     partial bytes discarded, mem_ack in that cycle ignored (pc not incremented), next
//     state F0 if en=1 else IDLE. Redirect coincident with valid&ready: instruction counts
//     as consumed, redirect still applied.
//   mem_ack while mem_req=0 is ignored. rst_n assertion mid-fetch aborts immediately.
//   Byte slots for unused positions always read 0 while instr_valid=1.
// TESTING
//   1 Reset, en=1, mem returns 00 with 0-wait ack -> instr_valid on cycle 2, byte0=00,
//     len=1, instr_pc=0; next fetch addr=1.
//   2 Memory 01,12,34 at 0x0010 (RESET_PC=0x0010) -> byte0=01, byte1=12, byte2=34,
//     ext=00, len=3, instr_pc=0x0010; next mem_addr=0x0013.
//   3 Memory 81,AA,BB,CC with 2-wait-state acks, instr_ready=0 for 5 cycles -> mem_addr
//     stable during waits; len=4, ext=CC; outputs stable all 5 cycles; one issue only.
//   4 redirect_valid to 0x0200 during F1 of a 3-byte instr with mem_ack high -> that byte
//     dropped, no instr_valid for partial instr, next mem_addr=0x0200.
//   5 PC at 0xFFFF fetching 3-byte instr -> bytes read from FFFF,0000,0001; instr_pc=FFFF.
//   6 en=0 asserted during F1 -> instruction completes and issues, then IDLE with mem_req=0.

Source files
------------

// File: rtl/instr_fetch_sequencer.sv
// Byte-serial fetch of 1/3/4-byte instructions into a decoder-facing valid/ready slot.
// Owns the program counter and honours branch redirects from execute at any time.
module instr_fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [7:0]        instr_byte0_o,
  output logic [7:0]        instr_byte1_o,
  output logic [7:0]        instr_byte2_o,
  output logic [7:0]        ext_instr_byte_o,
  output logic [2:0]        instr_len_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, ISSUE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [7:0]        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, ext_q, ext_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        new_len;
  logic [ADDR_W-1:0] pc_inc;

  function automatic logic [2:0] len_of(input logic [7:0] b);
    if (b[7])                 return 3'd4;
    else if (b[1:0] == 2'b00) return 3'd1;
    else                      return 3'd3;
  endfunction

  assign new_len = len_of(mem_rdata_i);
  assign pc_inc  = pc_q + ADDR_W'(1);

  // Redirect overrides everything, including an ack landing in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    ext_d   = ext_q;
    len_d   = len_q;
    if (redirect_valid_i) begin
      pc_d    = redirect_pc_i;
      state_d = en_i ? F0 : IDLE;
    end else begin
      case (state_q)
        IDLE: if (en_i) state_d = F0;
        F0: if (mem_ack_i) begin
          b0_d    = mem_rdata_i;
          b1_d    = 8'h00;
          b2_d    = 8'h00;
          ext_d   = 8'h00;
          len_d   = new_len;
          ipc_d   = pc_q;
          pc_d    = pc_inc;
          state_d = (new_len > 3'd1) ? F1 : ISSUE;
        end
        F1: if (mem_ack_i) begin
          b1_d    = mem_rdata_i;
          pc_d    = pc_inc;
          state_d = F2;
        end
        F2: if (mem_ack_i) begin
          b2_d    = mem_rdata_i;
          pc_d    = pc_inc;
          state_d = (len_q == 3'd4) ? F3 : ISSUE;
        end
        F3: if (mem_ack_i) begin
          ext_d   = mem_rdata_i;
          pc_d    = pc_inc;
          state_d = ISSUE;
        end
        ISSUE: if (instr_ready_i) state_d = en_i ? F0 : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= RESET_PC;
      b0_q    <= 8'h00;
      b1_q    <= 8'h00;
      b2_q    <= 8'h00;
      ext_q   <= 8'h00;
      len_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      ext_q   <= ext_d;
      len_q   <= len_d;
    end
  end

  assign mem_req_o        = (state_q == F0) || (state_q == F1) ||
                            (state_q == F2) || (state_q == F3);
  assign mem_addr_o       = pc_q;
  assign instr_valid_o    = (state_q == ISSUE);
  assign instr_byte0_o    = b0_q;
  assign instr_byte1_o    = b1_q;
  assign instr_byte2_o    = b2_q;
  assign ext_instr_byte_o = ext_q;
  assign instr_len_o      = len_q;
  assign instr_pc_o       = ipc_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Scoreboard bench for instr_fetch_sequencer: a byte memory model with wait states feeds
// the DUT while a monitor compares each presented instruction against queued expectations.
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck = 1'b0;
  logic [7:0]  memRdata = 8'h00;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [7:0]  byte0, byte1, byte2, extByte;
  logic [2:0]  instrLen;
  logic [15:0] instrPc;
  logic        redirValid = 1'b0;
  logic [15:0] redirPc = 16'h0000;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  ext;
    logic [2:0]  len;
    logic [15:0] pc;
  } expInstr_t;

  expInstr_t   scoreboard[$];
  logic [15:0] addrLog[$];
  logic [7:0]  mem [0:65535];
  int          waitStates = 0;
  int          waitCnt = 0;
  logic [15:0] holdAddr = 16'h0000;
  int          checkCount = 0;
  int          passCount = 0;

  always #5 clk = ~clk;

  instr_fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0010)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .mem_req_o(memReq), .mem_addr_o(memAddr), .mem_ack_i(memAck), .mem_rdata_i(memRdata),
    .instr_valid_o(instrValid), .instr_ready_i(instrReady),
    .instr_byte0_o(byte0), .instr_byte1_o(byte1), .instr_byte2_o(byte2),
    .ext_instr_byte_o(extByte), .instr_len_o(instrLen), .instr_pc_o(instrPc),
    .redirect_valid_i(redirValid), .redirect_pc_i(redirPc)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic enV, input logic readyV,
                               input logic redirV, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    en         = enV;
    instrReady = readyV;
    redirValid = redirV;
    redirPc    = rpc;
  endtask

  task automatic pushExpect(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] ext, input logic [2:0] len, input logic [15:0] pc);
    expInstr_t e;
    e.b0 = b0; e.b1 = b1; e.b2 = b2; e.ext = ext; e.len = len; e.pc = pc;
    scoreboard.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (scoreboard.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("drainTimeout", scoreboard.size(), 0);
  endtask

  // Byte memory: acks after waitStates idle cycles, holding the address must stay put.
  always @(negedge clk) begin
    if (!rst_n) begin
      memAck  = 1'b0;
      waitCnt = 0;
    end else if (memReq) begin
      if (waitCnt != 0) checkOutput("addrStable", memAddr, holdAddr);
      if (waitCnt == waitStates) begin
        memAck   = 1'b1;
        memRdata = mem[memAddr];
        waitCnt  = 0;
        addrLog.push_back(memAddr);
      end else begin
        memAck = 1'b0;
        if (waitCnt == 0) holdAddr = memAddr;
        waitCnt++;
      end
    end else begin
      memAck  = 1'b0;
      waitCnt = 0;
    end
  end

  // Monitor: every cycle an instruction is presented it must match the head entry.
  always @(negedge clk) begin
    if (rst_n && instrValid) begin
      if (scoreboard.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedIssue: got valid pc=%0h, expected no instruction", instrPc);
      end else begin
        checkOutput("byte0", byte0, scoreboard[0].b0);
        checkOutput("byte1", byte1, scoreboard[0].b1);
        checkOutput("byte2", byte2, scoreboard[0].b2);
        checkOutput("extByte", extByte, scoreboard[0].ext);
        checkOutput("instrLen", instrLen, scoreboard[0].len);
        checkOutput("instrPc", instrPc, scoreboard[0].pc);
        if (instrReady) void'(scoreboard.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h01; mem[16'h0011] = 8'h12; mem[16'h0012] = 8'h34;
    mem[16'h0100] = 8'h81; mem[16'h0101] = 8'hAA; mem[16'h0102] = 8'hBB; mem[16'h0103] = 8'hCC;
    mem[16'h0200] = 8'h00;
    mem[16'h0300] = 8'h05; mem[16'h0301] = 8'h66; mem[16'h0302] = 8'h77;
    mem[16'hFFFF] = 8'h02; mem[16'h0001] = 8'h5A;
    mem[16'h0400] = 8'h03; mem[16'h0401] = 8'h11; mem[16'h0402] = 8'h22;
    mem[16'h0500] = 8'h04; mem[16'h0501] = 8'h08; mem[16'h0502] = 8'h0C;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstMemReq", memReq, 0);
    checkOutput("rstMemAddr", memAddr, 16'h0010);
    checkOutput("rstValid", instrValid, 0);
    checkOutput("rstByte0", byte0, 0);
    checkOutput("rstLen", instrLen, 0);
    checkOutput("rstInstrPc", instrPc, 16'h0010);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 3-byte instruction from the reset PC
    pushExpect(8'h01, 8'h12, 8'h34, 8'h00, 3'd3, 16'h0010);
    applyStimulus(1, 1, 0, 16'h0000);
    applyStimulus(0, 1, 0, 16'h0000);
    waitDrain(30);
    checkOutput("t2NextAddr", memAddr, 16'h0013);
    checkOutput("t2IdleReq", memReq, 0);

    // 1-byte instruction after redirect to 0: valid two cycles after fetch starts
    pushExpect(8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 16'h0000);
    applyStimulus(1, 1, 1, 16'h0000);
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("t1FetchAddr", memAddr, 16'h0000);
    checkOutput("t1NotYetValid", instrValid, 0);
    @(posedge clk);
    #2;
    checkOutput("t1ValidCycle2", instrValid, 1);
    waitDrain(30);
    checkOutput("t1NextAddr", memAddr, 16'h0001);

    // 4-byte instruction, two wait states, decoder stalls for several cycles
    waitStates = 2;
    pushExpect(8'h81, 8'hAA, 8'hBB, 8'hCC, 3'd4, 16'h0100);
    applyStimulus(1, 0, 1, 16'h0100);
    applyStimulus(0, 0, 0, 16'h0000);
    begin
      int n = 0;
      while (!instrValid && n < 60) begin
        @(posedge clk);
        #2;
        n++;
      end
    end
    checkOutput("t3ValidSeen", instrValid, 1);
    repeat (5) @(negedge clk);
    checkOutput("t3HeldWhileStalled", scoreboard.size(), 1);
    applyStimulus(0, 1, 0, 16'h0000);
    waitDrain(30);
    checkOutput("t3NextAddr", memAddr, 16'h0104);
    waitStates = 0;

    // Redirect during F1 with ack high: partial instruction discarded
    pushExpect(8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 16'h0200);
    applyStimulus(1, 1, 1, 16'h0300);
    applyStimulus(1, 1, 0, 16'h0000);
    applyStimulus(1, 1, 1, 16'h0200);
    applyStimulus(0, 1, 0, 16'h0000);
    checkOutput("t4RedirAddr", memAddr, 16'h0200);
    checkOutput("t4RedirReq", memReq, 1);
    waitDrain(30);
    checkOutput("t4NextAddr", memAddr, 16'h0201);

    // PC wrap at the top of the address space
    addrLog.delete();
    pushExpect(8'h02, 8'h00, 8'h5A, 8'h00, 3'd3, 16'hFFFF);
    applyStimulus(1, 1, 1, 16'hFFFF);
    applyStimulus(0, 1, 0, 16'h0000);
    waitDrain(30);
    checkOutput("t5AddrCount", addrLog.size(), 3);
    if (addrLog.size() == 3) begin
      checkOutput("t5Addr0", addrLog[0], 16'hFFFF);
      checkOutput("t5Addr1", addrLog[1], 16'h0000);
      checkOutput("t5Addr2", addrLog[2], 16'h0001);
    end
    checkOutput("t5NextAddr", memAddr, 16'h0002);

    // en drops during F1: instruction still completes, then sequencer idles
    pushExpect(8'h03, 8'h11, 8'h22, 8'h00, 3'd3, 16'h0400);
    applyStimulus(1, 1, 1, 16'h0400);
    applyStimulus(1, 1, 0, 16'h0000);
    applyStimulus(0, 1, 0, 16'h0000);
    waitDrain(30);
    checkOutput("t6IdleReq", memReq, 0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("t6StillIdleReq", memReq, 0);
    checkOutput("t6StillNoValid", instrValid, 0);
    checkOutput("t6HoldAddr", memAddr, 16'h0403);

    // Back-to-back 1-byte instructions with en held high
    pushExpect(8'h04, 8'h00, 8'h00, 8'h00, 3'd1, 16'h0500);
    pushExpect(8'h08, 8'h00, 8'h00, 8'h00, 3'd1, 16'h0501);
    pushExpect(8'h0C, 8'h00, 8'h00, 8'h00, 3'd1, 16'h0502);
    applyStimulus(1, 1, 1, 16'h0500);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 16'h0000);
    applyStimulus(0, 1, 0, 16'h0000);
    waitDrain(30);
    @(posedge clk);
    #2;
    checkOutput("streamNextAddr", memAddr, 16'h0503);
    checkOutput("streamIdleReq", memReq, 0);

    // Asynchronous reset in the middle of a stalled fetch
    waitStates = 2;
    applyStimulus(1, 1, 1, 16'h0600);
    applyStimulus(0, 1, 0, 16'h0000);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstReq", memReq, 0);
    checkOutput("midRstAddr", memAddr, 16'h0010);
    checkOutput("midRstByte0", byte0, 0);
    checkOutput("midRstInstrPc", instrPc, 16'h0010);
    repeat (2) @(posedge clk);
    checkOutput("scoreboardEmpty", scoreboard.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
